// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus: pipeline-side hazard inputs and the stall/bubble/flush controls.
// The pipeline is the master; the hazard controller is the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int PERF_W = 32
);
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [4:0]        ex_rd_addr;
    logic              ex_reg_write_en;
    logic [1:0]        ex_mem_read;
    logic              ex_is_muldiv;
    logic              ex_branch_taken;
    logic              mem_busy;

    logic              pc_stall;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_stall;
    logic              id_ex_bubble;
    logic              ex_mem_stall;
    logic              ex_mem_bubble;
    logic              mem_wb_bubble;
    logic              muldiv_start;
    logic              muldiv_busy;
    logic [PERF_W-1:0] stall_count;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_reg_write_en, ex_mem_read, ex_is_muldiv,
               ex_branch_taken, mem_busy,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               ex_mem_stall, ex_mem_bubble, mem_wb_bubble, muldiv_start,
               muldiv_busy, stall_count
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_reg_write_en, ex_mem_read, ex_is_muldiv,
               ex_branch_taken, mem_busy,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               ex_mem_stall, ex_mem_bubble, mem_wb_bubble, muldiv_start,
               muldiv_busy, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32IM pipeline: load-use, mul/div hold,
// taken-branch flush and data-memory wait, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 6,
    parameter int PERF_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PERF_W-1:0]  r_stall_count;

    logic w_lu, w_md_start, w_md_hold;
    logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall, w_id_ex_bubble;
    logic w_ex_mem_stall, w_ex_mem_bubble, w_mem_wb_bubble, w_muldiv_start, w_muldiv_busy;

    assign w_lu = (hz.ex_mem_read != 2'd0) && hz.ex_reg_write_en && (hz.ex_rd_addr != 5'd0) &&
                  ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                   (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

    // The release cycle (BUSY, cnt==0) claims no priority: it stalls nothing.
    assign w_md_start = (r_state == IDLE) && hz.ex_is_muldiv;
    assign w_md_hold  = (r_state == BUSY) && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!hz.mem_busy) begin
            case (r_state)
                IDLE: if (hz.ex_is_muldiv) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
                BUSY: if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
                      else             w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_stall  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_mem_wb_bubble = 1'b0;
        w_muldiv_start  = 1'b0;
        // Status flag: tracks BUSY even through a memory wait.
        w_muldiv_busy   = !reset && (r_state == BUSY);
        if (reset) begin
            w_pc_stall = 1'b0;
        end else if (hz.mem_busy) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_stall  = 1'b1;
            w_mem_wb_bubble = 1'b1;
        end else if (w_md_start || w_md_hold) begin
            w_muldiv_start  = w_md_start;
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_bubble = 1'b1;
        end else if (hz.ex_branch_taken) begin
            w_if_id_flush   = 1'b1;
            w_id_ex_bubble  = 1'b1;
        end else if (w_lu) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_count <= '0;
        else if (w_pc_stall && (r_stall_count != PERF_MAX))
            r_stall_count <= r_stall_count + PERF_W'(1);
    end

    assign hz.pc_stall      = w_pc_stall;
    assign hz.if_id_stall   = w_if_id_stall;
    assign hz.if_id_flush   = w_if_id_flush;
    assign hz.id_ex_stall   = w_id_ex_stall;
    assign hz.id_ex_bubble  = w_id_ex_bubble;
    assign hz.ex_mem_stall  = w_ex_mem_stall;
    assign hz.ex_mem_bubble = w_ex_mem_bubble;
    assign hz.mem_wb_bubble = w_mem_wb_bubble;
    assign hz.muldiv_start  = w_muldiv_start;
    assign hz.muldiv_busy   = w_muldiv_busy;
    assign hz.stall_count   = r_stall_count;
endmodule
